// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared types and constants for the pipeline stall controller
// Purpose: FSM state enum, per-cycle action encoding in redirect-priority order,
//          pipeline control bundle and the action-to-control mapping.
// Ports:   none (package)
package pipe_stall_ctrl_pkg;

    localparam int DEFAULT_CNT_W = 32;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Enumerated in priority order: the first matching RUN action wins.
    // ACT_HALTED is the action taken for every cycle spent in HALT.
    typedef enum logic [2:0] {
        ACT_BRANCH = 3'd0,
        ACT_HALT   = 3'd1,
        ACT_JUMP   = 3'd2,
        ACT_STALL  = 3'd3,
        ACT_NONE   = 3'd4,
        ACT_HALTED = 3'd5
    } action_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    // Controls held while rst is asserted: freeze PC and IF/ID, nop both stages.
    localparam ctrl_t CTRL_RESET = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};

    function automatic ctrl_t ctrl_for(action_e act);
        ctrl_t c;
        c = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
        case (act)
            ACT_BRANCH: c = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
            ACT_JUMP:   c = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0};
            ACT_HALT,
            ACT_STALL,
            ACT_HALTED: c = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
            default:    c = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// rtl/pipe_stall_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts cycles where inc is high, sticks at all-ones, clr (or rst) forces 0.
// Ports:   clk   in  clock
//          rst   in  synchronous active-high reset
//          inc   in  increment request this cycle
//          clr   in  synchronous clear, wins over inc
//          q     out current count [CNT_W-1:0]
module sat_counter
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush controller with HALT/RUN machine and statistics
// Purpose: turns stall request, EX branch redirect, ID jump and halt into PC/IF/ID/ID-EX
//          controls (combinational, zero latency), runs the HALT/RUN FSM, keeps saturating
//          hazard statistics and flags a stall held longer than MAX_STALL cycles.
// Ports:   clk, rst (sync active-high)
//          stall_req, branch_taken, jump, halt, go, fwd_hit, clr_cnt   in
//          pc_en, ifid_en, ifid_flush, idex_flush                      out controls
//          halted, stall_timeout                                       out status
//          cycle_cnt, stall_cnt, flush_cnt, fwd_cnt [CNT_W-1:0]        out statistics
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W     = DEFAULT_CNT_W,
    parameter int MAX_STALL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_req,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             halt,
    input  logic             go,
    input  logic             fwd_hit,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    // Run-length only needs to reach MAX_STALL+1 to know the limit was passed.
    localparam int              RL_W   = $clog2(MAX_STALL + 2);
    localparam logic [RL_W-1:0] RL_MAX = RL_W'(MAX_STALL);
    localparam logic [RL_W-1:0] RL_SAT = RL_W'(MAX_STALL + 1);

    state_e          state_q, state_d;
    logic [RL_W-1:0] run_len_q, run_len_d;
    logic            timeout_q, timeout_d;
    action_e         act;
    ctrl_t           ctrl;

    logic stall_applied;
    logic redirect_applied;
    logic fwd_counted;
    logic in_run;

    // Priority encoder: an EX branch squashes everything younger in ID.
    always_comb begin
        act = ACT_NONE;
        if (state_q == ST_HALT) begin
            act = ACT_HALTED;
        end else if (branch_taken) begin
            act = ACT_BRANCH;
        end else if (halt) begin
            act = ACT_HALT;
        end else if (jump) begin
            act = ACT_JUMP;
        end else if (stall_req) begin
            act = ACT_STALL;
        end
    end

    always_comb begin
        ctrl = ctrl_for(act);
        if (rst) begin
            ctrl = CTRL_RESET;
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign ifid_en    = ctrl.ifid_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;
    assign halted     = (state_q == ST_HALT) && !rst;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (act == ACT_HALT) state_d = ST_HALT;
            ST_HALT: if (go)              state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    assign in_run           = (state_q == ST_RUN);
    assign stall_applied    = (act == ACT_STALL);
    assign redirect_applied = (act == ACT_BRANCH) || (act == ACT_JUMP);
    assign fwd_counted      = fwd_hit && in_run && !branch_taken && !stall_applied;

    // Timeout fires on the stall cycle that would push the run past MAX_STALL;
    // clr_cnt drops the flag but does not restart the ongoing run.
    always_comb begin
        run_len_d = '0;
        if (stall_applied) begin
            run_len_d = (run_len_q == RL_SAT) ? run_len_q : run_len_q + RL_W'(1);
        end
        timeout_d = timeout_q | (stall_applied && (run_len_q >= RL_MAX));
        if (clr_cnt) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            run_len_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk (clk), .rst (rst), .inc (in_run),           .clr (clr_cnt), .q (cycle_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk), .rst (rst), .inc (stall_applied),    .clr (clr_cnt), .q (stall_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk), .rst (rst), .inc (redirect_applied), .clr (clr_cnt), .q (flush_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_fwd_cnt (
        .clk (clk), .rst (rst), .inc (fwd_counted),      .clr (clr_cnt), .q (fwd_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

    localparam int CNT_W     = 4;
    localparam int MAX_STALL = 3;
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, stall_req, branch_taken, jump, halt, go, fwd_hit, clr_cnt;
    logic             pc_en, ifid_en, ifid_flush, idex_flush, halted, stall_timeout;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt, fwd_cnt;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .halt          (halt),
        .go            (go),
        .fwd_hit       (fwd_hit),
        .clr_cnt       (clr_cnt),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .halted        (halted),
        .stall_timeout (stall_timeout),
        .cycle_cnt     (cycle_cnt),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .fwd_cnt       (fwd_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integers and booleans following the cycle rules.
    bit m_valid = 0;
    bit m_halted;
    int m_cycle, m_stall, m_flush, m_fwd;
    int m_run;
    bit m_to;

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    function automatic logic [3:0] model_ctrl();
        if (rst)           return 4'b0011;
        if (m_halted)      return 4'b0001;
        if (branch_taken)  return 4'b1111;
        if (halt)          return 4'b0001;
        if (jump)          return 4'b1110;
        if (stall_req)     return 4'b0001;
        return 4'b1100;
    endfunction

    task automatic model_update();
        bit running, stall_app, redir, fwd_app;
        if (rst) begin
            m_valid = 1; m_halted = 0; m_cycle = 0; m_stall = 0; m_flush = 0; m_fwd = 0;
            m_run = 0; m_to = 0;
            return;
        end
        running   = !m_halted;
        stall_app = running && !branch_taken && !halt && !jump && stall_req;
        redir     = running && (branch_taken || (!halt && jump));
        fwd_app   = running && fwd_hit && !branch_taken && !stall_app;
        m_run     = stall_app ? m_run + 1 : 0;
        if (clr_cnt) begin
            m_cycle = 0; m_stall = 0; m_flush = 0; m_fwd = 0; m_to = 0;
        end else begin
            if (running)   m_cycle = sat_inc(m_cycle);
            if (stall_app) m_stall = sat_inc(m_stall);
            if (redir)     m_flush = sat_inc(m_flush);
            if (fwd_app)   m_fwd   = sat_inc(m_fwd);
            if (m_run > MAX_STALL) m_to = 1;
        end
        m_halted = m_halted ? !go : (!branch_taken && halt);
    endtask

    task automatic check_all();
        chk("ctrl", {pc_en, ifid_en, ifid_flush, idex_flush}, model_ctrl());
        if (m_valid) begin
            chk("halted",        halted,        rst ? 1'b0 : m_halted);
            chk("stall_timeout", stall_timeout, m_to);
            chk("cycle_cnt",     cycle_cnt,     m_cycle);
            chk("stall_cnt",     stall_cnt,     m_stall);
            chk("flush_cnt",     flush_cnt,     m_flush);
            chk("fwd_cnt",       fwd_cnt,       m_fwd);
        end
    endtask

    task automatic drive(input logic r, s, b, j, h, g, f, c);
        rst = r; stall_req = s; branch_taken = b; jump = j;
        halt = h; go = g; fwd_hit = f; clr_cnt = c;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // One full cycle: drive, check at the falling edge, advance model on the rising edge.
    task automatic cyc(input logic r, s, b, j, h, g, f, c);
        drive(r, s, b, j, h, g, f, c);
        @(negedge clk);
        check_all();
        finish_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic r, s, b, j, h, g, f, c;
        logic [3:0] ctrl;   // {pc_en, ifid_en, ifid_flush, idex_flush}
        logic       hl;
    } vec_t;

    vec_t tbl[11];

    initial begin
        //           r  s  b  j  h  g  f  c   ctrl     halted
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 1'b0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 1, 0, 4'b1100, 1'b0};
        tbl[2]  = '{0, 1, 0, 0, 0, 0, 1, 0, 4'b0001, 1'b0};
        tbl[3]  = '{0, 0, 0, 1, 0, 0, 0, 0, 4'b1110, 1'b0};
        tbl[4]  = '{0, 1, 1, 0, 1, 0, 0, 0, 4'b1111, 1'b0};
        tbl[5]  = '{0, 1, 0, 1, 0, 0, 1, 0, 4'b1110, 1'b0};
        tbl[6]  = '{0, 0, 0, 1, 1, 0, 0, 0, 4'b0001, 1'b0};
        tbl[7]  = '{0, 1, 1, 1, 0, 0, 1, 0, 4'b0001, 1'b1};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 0, 0, 4'b0001, 1'b1};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 1'b0};
        tbl[10] = '{1, 1, 0, 0, 1, 0, 0, 0, 4'b0011, 1'b0};

        // Reset: two cycles, then everything idle.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_cycle",  cycle_cnt, 0);
        chk("rst_stall",  stall_cnt, 0);
        chk("rst_flush",  flush_cnt, 0);
        chk("rst_fwd",    fwd_cnt, 0);
        chk("rst_to",     stall_timeout, 1'b0);

        // Control table.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].j, tbl[i].h, tbl[i].g, tbl[i].f, tbl[i].c);
            @(negedge clk);
            check_all();
            chk($sformatf("tbl%0d_ctrl", i), {pc_en, ifid_en, ifid_flush, idex_flush}, tbl[i].ctrl);
            chk($sformatf("tbl%0d_halted", i), halted, tbl[i].hl);
            finish_cycle();
        end

        // Load-use single stall.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu_ctrl", {pc_en, ifid_en, idex_flush}, 3'b001);
        check_all();
        finish_cycle();
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_to", stall_timeout, 1'b0);

        // Branch + stall + halt together: branch wins, stays RUN.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 0, 0, 0);
        chk("bsh_flush_cnt", flush_cnt, 1);
        chk("bsh_stall_cnt", stall_cnt, 0);
        chk("bsh_halted", halted, 1'b0);

        // Halt, idle in HALT with cycle_cnt frozen, resume with go.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("h_halted", halted, 1'b1);
        chk("h_cycle", cycle_cnt, 1);
        cyc(0, 1, 1, 1, 1, 0, 1, 0);
        idle(4);
        chk("h_cycle_frozen", cycle_cnt, 1);
        chk("h_still_halted", halted, 1'b1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("h_resumed", halted, 1'b0);
        chk("h_cycle_go", cycle_cnt, 1);

        // Stuck stall: timeout on the 4th stall edge, not the 3rd.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
        chk("ss_to_3", stall_timeout, 1'b0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        chk("ss_to_4", stall_timeout, 1'b1);
        idle(2);
        chk("ss_sticky", stall_timeout, 1'b1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("ss_clr", stall_timeout, 1'b0);

        // Saturation at CNT_W=4.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("sat_fwd", fwd_cnt, 15);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("sat_clr", fwd_cnt, 0);

        // Randomized run against the model.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 0,
                $urandom_range(0, 39) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
